// File: rtl/mem_port_sequencer_if.sv
// Shared memory port bus between the pipeline sequencer (master) and the memory (slave).
interface mem_port_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_sequencer.sv
// Shares one memory port between data access and instruction fetch.
// Each step does data first, then fetch, then emits one pipe_advance pulse.
//
// state  | meaning
// IDLE   | sample requests and issue the first access of the step
// D_WAIT | data load/store in flight
// F_WAIT | instruction fetch in flight
// ADV    | step complete, pipe_advance high for this cycle
module mem_port_sequencer #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        if_req,
    input  logic [15:0]                 if_addr,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [15:0]                 d_addr,
    input  logic [15:0]                 d_wdata,
    mem_port_sequencer_if.master        mem,
    output logic [15:0]                 if_instr,
    output logic [15:0]                 d_rdata,
    output logic                        pipe_advance,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [15:0]                 stall_count
);
    typedef enum logic [1:0] {IDLE, D_WAIT, F_WAIT, ADV} state_t;

    localparam logic [16:0] LIMIT = 17'(WAIT_LIMIT);

    state_t      state, state_nxt;
    logic        req_q, req_d, we_q, we_d, terr_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [15:0] instr_d, rdata_d, cnt_q, cnt_d, stall_d;
    logic        in_wait, limit_hit, done;

    assign in_wait   = (state == D_WAIT) || (state == F_WAIT);
    // An ack in the same cycle the limit is reached wins over the abandon.
    assign limit_hit = !mem.mem_ack && (({1'b0, cnt_q} + 17'd1) == LIMIT);
    assign done      = in_wait && (mem.mem_ack || limit_hit);

    always_ff @(posedge clk) begin
        if (reset_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_write || d_read) state_nxt = D_WAIT;
                else if (if_req)       state_nxt = F_WAIT;
                else                   state_nxt = ADV;
            end
            D_WAIT:  if (done) state_nxt = if_req ? F_WAIT : ADV;
            F_WAIT:  if (done) state_nxt = ADV;
            ADV:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = if_instr;
        rdata_d = d_rdata;
        cnt_d   = cnt_q;
        terr_d  = timeout_err;
        stall_d = (!pipe_advance && stall_count != 16'hFFFF) ? stall_count + 16'd1 : stall_count;
        case (state)
            IDLE: begin
                cnt_d = 16'd0;
                if (d_write) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (d_read) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = d_addr;
                end else if (if_req) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = if_addr;
                end
            end
            D_WAIT: begin
                if (done) begin
                    cnt_d = 16'd0;
                    if (mem.mem_ack && !we_q) rdata_d = mem.mem_rdata;
                    if (limit_hit)            terr_d  = 1'b1;
                    we_d = 1'b0;
                    // Fetch reissues straight off the data completion with no idle cycle.
                    if (if_req) begin
                        addr_d = if_addr;
                    end else begin
                        req_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            F_WAIT: begin
                if (done) begin
                    cnt_d = 16'd0;
                    req_d = 1'b0;
                    if (mem.mem_ack) begin
                        instr_d = mem.mem_rdata;
                    end else begin
                        instr_d = NOP_INSTR;
                        terr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 16'd0;
            wdata_q      <= 16'd0;
            if_instr     <= NOP_INSTR;
            d_rdata      <= 16'd0;
            pipe_advance <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            stall_count  <= 16'd0;
            cnt_q        <= 16'd0;
        end else begin
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_instr     <= instr_d;
            d_rdata      <= rdata_d;
            pipe_advance <= (state_nxt == ADV);
            busy         <= (state_nxt != IDLE);
            timeout_err  <= terr_d;
            stall_count  <= stall_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule
